// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, widths and the response FIFO entry layout.
package alu_pkg;
  localparam int DATA_W = 32;
  localparam int ALU_LATENCY = 2;
  localparam int MAX_ID_W = 3;
  localparam logic [4:0] OP_NOP = 5'b11111;
  typedef enum logic [4:0] {
    OP_ADD = 5'd0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
    OP_SLL, OP_SRL, OP_SRA, OP_NOR, OP_SGE = 5'd10
  } alu_op_t;
  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [DATA_W-1:0]   result;
    logic                zero;
  } rsp_entry_t;
endpackage

// File: rtl/alu_issue_arbiter_if.sv
// alu_issue_arbiter_if: requester-side request bus and consumer-side response bus.
interface alu_issue_arbiter_if import alu_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*5-1:0]      req_op;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_zero;
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: first-word-fall-through response FIFO with occupancy count.
module alu_rsp_fifo import alu_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  rsp_entry_t    push_data,
  input  logic          pop,
  output rsp_entry_t    head,
  output logic          valid,
  output logic [CW-1:0] count
);
  rsp_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic pop_eff;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign valid = count != '0;
  assign pop_eff = pop & valid;
  // Head is masked so the outputs read zero while empty, including after reset.
  assign head = valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop_eff) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop_eff);
    end
endmodule

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin, credit-limited issue of requester ops to a shared
// 2-stage ALU, with an ID shadow pipeline feeding an in-order response FIFO.
module alu_issue_arbiter import alu_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ),
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_issue_arbiter_if.slave bus,
  output logic [DATA_W-1:0] alu_operand_a,
  output logic [DATA_W-1:0] alu_operand_b,
  output logic [4:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int UW = CW + 1;
  localparam int SW = ID_W + 1;
  logic [ID_W-1:0] rr, sel, gid, id0, id1;
  logic [SW-1:0] sum;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0] rot;
  logic found, grant, v0, v1, head_valid;
  logic [UW-1:0] used;
  logic [CW-1:0] count;
  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];
  logic [4:0] op_arr [NUM_REQ];
  rsp_entry_t head;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]  = bus.req_a[g*DATA_W +: DATA_W];
    assign b_arr[g]  = bus.req_b[g*DATA_W +: DATA_W];
    assign op_arr[g] = bus.req_op[g*5 +: 5];
  end
  // Rotate valids so bit 0 is the rr pointer; the lowest set bit is the winner.
  assign dbl = {bus.req_valid, bus.req_valid} >> rr;
  assign rot = dbl[NUM_REQ-1:0];
  always_comb begin
    found = 1'b0;
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) begin
        found = 1'b1;
        sel = ID_W'(k);
      end
  end
  assign sum = {1'b0, rr} + {1'b0, sel};
  assign gid = sum >= SW'(NUM_REQ) ? ID_W'(sum - SW'(NUM_REQ)) : sum[ID_W-1:0];
  // Credits ignore a same-cycle pop, so a stalled consumer can never overflow the FIFO.
  assign used = UW'(count) + UW'(v0) + UW'(v1);
  assign grant = reset_n & found & (used < UW'(RSP_DEPTH));
  assign bus.req_ready = grant ? NUM_REQ'(1) << gid : '0;
  assign alu_operand_a = grant ? a_arr[gid] : '0;
  assign alu_operand_b = grant ? b_arr[gid] : '0;
  assign alu_op = grant ? op_arr[gid] : OP_NOP;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rr  <= '0;
      v0  <= 1'b0;
      v1  <= 1'b0;
      id0 <= '0;
      id1 <= '0;
    end else begin
      rr  <= grant ? (gid == ID_W'(NUM_REQ - 1) ? '0 : gid + 1'b1) : rr;
      v0  <= grant;
      id0 <= gid;
      v1  <= v0;
      id1 <= id0;
    end
  alu_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (v1),
    .push_data ('{id: MAX_ID_W'(id1), result: alu_result, zero: alu_zero}),
    .pop       (bus.rsp_ready),
    .head      (head),
    .valid     (head_valid),
    .count     (count)
  );
  assign bus.rsp_valid  = head_valid;
  assign bus.rsp_id     = ID_W'(head.id);
  assign bus.rsp_result = head.result;
  assign bus.rsp_zero   = head.zero;
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed vectors plus randomized traffic checked against
// a queue-based model of issue order, credits and response timing.
module tb_alu_issue_arbiter;
  import alu_pkg::*;
  localparam int NUM_REQ = 4;
  localparam int RSP_DEPTH = 4;
  typedef struct {
    int id;
    logic [4:0] op;
    logic [31:0] a, b, res;
    logic z;
  } vec_t;
  typedef struct {
    int id;
    logic [31:0] res;
    logic z;
    int due;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] alu_operand_a, alu_operand_b, alu_result;
  logic [4:0] alu_op;
  logic alu_zero;
  logic [4:0] s_op;
  logic [31:0] s_a, s_b;
  logic [NUM_REQ-1:0] rv = '0;
  logic rdy = 1'b1;
  logic [31:0] ra [NUM_REQ];
  logic [31:0] rb [NUM_REQ];
  logic [4:0] ro [NUM_REQ];
  exp_t q[$];
  int rr_m = 0;
  int last_gnt = -1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  vec_t tv [10];
  alu_issue_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
  alu_issue_arbiter #(.NUM_REQ(NUM_REQ), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_op        (alu_op),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero)
  );
  always #5 clk = ~clk;
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[32*i +: 32] = ra[i];
      bus.req_b[32*i +: 32] = rb[i];
      bus.req_op[5*i +: 5]  = ro[i];
    end
    bus.req_valid = rv;
    bus.rsp_ready = rdy;
  end
  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return {31'b0, $signed(a) < $signed(b)};
      5'd6:    return a << b[4:0];
      5'd7:    return a >> b[4:0];
      5'd8:    return 32'($signed(a) >>> b[4:0]);
      5'd9:    return ~(a | b);
      5'd10:   return {31'b0, $signed(a) >= $signed(b)};
      default: return 32'h0;
    endcase
  endfunction
  // External 2-stage ALU: operands registered, then result registered.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s_op <= OP_NOP;
      s_a <= '0;
      s_b <= '0;
      alu_result <= '0;
      alu_zero <= 1'b1;
    end else begin
      s_op <= alu_op;
      s_a <= alu_operand_a;
      s_b <= alu_operand_b;
      alu_result <= alu_f(s_op, s_a, s_b);
      alu_zero <= alu_f(s_op, s_a, s_b) == 32'h0;
    end
  always @(posedge clk)
    if (reset_n)
      assert (!(dut.u_fifo.push && !dut.u_fifo.pop_eff && dut.u_fifo.count == 3'(RSP_DEPTH)))
      else begin
        failures++;
        $display("FAIL fifo_overflow: push into full FIFO at cycle %0d", cyc);
      end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // One cycle: check outputs against the model, advance the model, wait for next negedge.
  task automatic step();
    int g;
    bit hv;
    #1;
    g = -1;
    if (!reset_n) begin
      q.delete();
      rr_m = 0;
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 0);
      chk("rst_rsp_result", bus.rsp_result, 0);
      chk("rst_rsp_zero", 32'(bus.rsp_zero), 0);
      chk("rst_alu_op", 32'(alu_op), 32'(OP_NOP));
      chk("rst_alu_a", alu_operand_a, 0);
    end else begin
      if (q.size() < RSP_DEPTH)
        for (int k = 0; k < NUM_REQ; k++)
          if (g < 0 && rv[(rr_m + k) % NUM_REQ]) g = (rr_m + k) % NUM_REQ;
      chk("req_ready", 32'(bus.req_ready), g < 0 ? 0 : 32'(1) << g);
      chk("alu_op", 32'(alu_op), g < 0 ? 32'(OP_NOP) : 32'(ro[g]));
      chk("alu_a", alu_operand_a, g < 0 ? 0 : ra[g]);
      chk("alu_b", alu_operand_b, g < 0 ? 0 : rb[g]);
      hv = q.size() > 0 && q[0].due <= cyc;
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(hv));
      if (hv) begin
        chk("rsp_id", 32'(bus.rsp_id), q[0].id);
        chk("rsp_result", bus.rsp_result, q[0].res);
        chk("rsp_zero", 32'(bus.rsp_zero), 32'(q[0].z));
        if (rdy) void'(q.pop_front());
      end
      if (g >= 0) begin
        q.push_back('{id: g, res: alu_f(ro[g], ra[g], rb[g]), z: alu_f(ro[g], ra[g], rb[g]) == 0, due: cyc + 3});
        rr_m = (g + 1) % NUM_REQ;
      end
    end
    last_gnt = g;
    cyc++;
    @(negedge clk);
  endtask
  task automatic apply_vec(input vec_t v);
    rdy = 1'b1;
    rv = '0;
    rv[v.id] = 1'b1;
    ro[v.id] = v.op;
    ra[v.id] = v.a;
    rb[v.id] = v.b;
    step();
    rv = '0;
    chk("lat_c1_valid", 32'(bus.rsp_valid), 0);
    step();
    chk("lat_c2_valid", 32'(bus.rsp_valid), 0);
    step();
    chk("vec_valid", 32'(bus.rsp_valid), 1);
    chk("vec_id", 32'(bus.rsp_id), v.id);
    chk("vec_result", bus.rsp_result, v.res);
    chk("vec_zero", 32'(bus.rsp_zero), 32'(v.z));
    step();
  endtask
  initial begin
    int cnt;
    for (int i = 0; i < NUM_REQ; i++) begin
      ra[i] = '0;
      rb[i] = '0;
      ro[i] = OP_NOP;
    end
    tv[0] = '{2, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0};
    tv[1] = '{1, OP_SUB, 32'd9, 32'd9, 32'd0, 1'b1};
    tv[2] = '{0, OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0};
    tv[3] = '{3, 5'b01100, 32'h1234, 32'h5678, 32'd0, 1'b1};
    tv[4] = '{1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0};
    tv[5] = '{2, OP_SGE, 32'd3, 32'd5, 32'd0, 1'b1};
    tv[6] = '{3, OP_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0};
    tv[7] = '{0, OP_SLL, 32'd1, 32'd31, 32'h8000_0000, 1'b0};
    tv[8] = '{1, OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0};
    tv[9] = '{2, OP_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0};
    @(negedge clk);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) apply_vec(tv[i]);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      ra[i] = 32'(i * 10);
      rb[i] = 32'(i);
      ro[i] = OP_ADD;
    end
    rv = '1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("rr_order", 32'(last_gnt), 32'(k % NUM_REQ));
      if (k >= 2) chk("no_bubble", 32'(bus.rsp_valid), 1);
    end
    rv = '0;
    repeat (6) step();
    rdy = 1'b0;
    rv = '1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (last_gnt >= 0) cnt++;
    end
    chk("credit_limit", 32'(cnt), 32'(RSP_DEPTH));
    chk("stall_ready", 32'(bus.req_ready), 0);
    rdy = 1'b1;
    rv = '0;
    repeat (6) step();
    chk("drained", 32'(bus.rsp_valid), 0);
    rv = '1;
    step();
    chk("resume", 32'(last_gnt >= 0), 1);
    rv = '0;
    repeat (6) step();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rv = '0;
      rv[k] = 1'b1;
      ro[k] = OP_ADD;
      ra[k] = 32'(k + 1);
      rb[k] = 32'd1;
      step();
    end
    rv = '0;
    chk("pre_rst_valid", 32'(bus.rsp_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(bus.rsp_valid), 0);
    step();
    step();
    reset_n = 1'b1;
    rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_rst_quiet", 32'(bus.rsp_valid), 0);
    end
    apply_vec('{1, OP_ADD, 32'd100, 32'd23, 32'd123, 1'b0});
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!rv[i] || last_gnt == i) begin
          rv[i] = $urandom_range(0, 2) != 0;
          ra[i] = $urandom;
          rb[i] = $urandom_range(0, 3) == 0 ? ra[i] : $urandom;
          ro[i] = 5'($urandom_range(0, 12));
        end
      rdy = $urandom_range(0, 3) != 0;
      step();
    end
    rv = '0;
    rdy = 1'b1;
    repeat (8) step();
    chk("final_empty", 32'(bus.rsp_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
